// File: rtl/dequantizer_mt.sv
// dequantizer_mt
//   Multi-table dequantizer sitting between the zigzag reorder and the IDCT.
//   Each coefficient is multiplied by an entry of one of TBL_NUM run-time
//   loadable quant tables, scaled up by FRAC_BIT bits and saturated to
//   OUT_BIT. Two-stage valid/ready pipeline, one coefficient per cycle.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   tbl_yaz_*                table write port (valid/ready, select, row-major
//                            address, value)
//   zig_veri_*, zig_tbl_sec_i, zig_blok_son_i
//                            coefficient input with row/col, table select,
//                            last-of-block marker (valid/ready)
//   idct_veri_*, idct_doyma_o, idct_blok_son_o
//                            dequantized output with row/col, saturation flag,
//                            last-of-block marker (valid/ready)
//   blok_hata_o              sticky: a block ended with a count other than 64
//
// State | meaning
// ------+-----------------------------------------------------------------
// BOSTA | idle between blocks, pipeline empty; table writes allowed
// BLOK  | inside a block; table writes blocked
// BOSALT| last coefficient taken, pipeline draining; next block may start
module dequantizer_mt #(
  parameter int IN_BIT    = 12,
  parameter int TBL_BIT   = 8,
  parameter int TBL_NUM   = 4,
  parameter int OUT_BIT   = 24,
  parameter int FRAC_BIT  = 8,
  parameter int BLOCK_BIT = 3,
  localparam int SEL_BIT  = (TBL_NUM > 1) ? $clog2(TBL_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tbl_yaz_gecerli_i,
  input  logic [SEL_BIT-1:0]   tbl_yaz_sec_i,
  input  logic [5:0]           tbl_yaz_adr_i,
  input  logic [TBL_BIT-1:0]   tbl_yaz_veri_i,
  output logic                 tbl_yaz_hazir_o,
  input  logic [IN_BIT-1:0]    zig_veri_i,
  input  logic [BLOCK_BIT-1:0] zig_veri_row_i,
  input  logic [BLOCK_BIT-1:0] zig_veri_col_i,
  input  logic [SEL_BIT-1:0]   zig_tbl_sec_i,
  input  logic                 zig_veri_gecerli_i,
  input  logic                 zig_blok_son_i,
  output logic                 zig_veri_hazir_o,
  output logic [OUT_BIT-1:0]   idct_veri_o,
  output logic [BLOCK_BIT-1:0] idct_veri_row_o,
  output logic [BLOCK_BIT-1:0] idct_veri_col_o,
  output logic                 idct_doyma_o,
  output logic                 idct_veri_gecerli_o,
  output logic                 idct_blok_son_o,
  input  logic                 idct_veri_hazir_i,
  output logic                 blok_hata_o
);

  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] BLOK   = 2'd1;
  localparam logic [1:0] BOSALT = 2'd2;

  localparam int PROD_BIT = IN_BIT + TBL_BIT + 1;
  localparam int SHF_BIT  = PROD_BIT + FRAC_BIT;
  // one spare bit so the clamp compare never sees a wrapped value
  localparam int WIDE_BIT = ((SHF_BIT > OUT_BIT) ? SHF_BIT : OUT_BIT) + 1;

  localparam logic signed [WIDE_BIT-1:0] MAXV = WIDE_BIT'((64'sd1 <<< (OUT_BIT-1)) - 64'sd1);
  localparam logic signed [WIDE_BIT-1:0] MINV = WIDE_BIT'(-(64'sd1 <<< (OUT_BIT-1)));

  // JPEG Annex K luminance table, row-major
  localparam logic [7:0] LUMA [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // out-of-range selects fall back to table 0
  function automatic logic [SEL_BIT-1:0] sel_fix(input logic [SEL_BIT-1:0] s);
    return (32'(s) >= TBL_NUM) ? '0 : s;
  endfunction

  logic [TBL_BIT-1:0] tbl_q [TBL_NUM][64];

  logic [1:0]   fsm_q, fsm_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         hata_q, hata_d;

  logic                 s1_vld_q;
  logic [IN_BIT-1:0]    s1_coef_q;
  logic [BLOCK_BIT-1:0] s1_row_q, s1_col_q;
  logic                 s1_son_q;
  logic [TBL_BIT-1:0]   s1_ent_q;

  logic                 s2_vld_q;
  logic [OUT_BIT-1:0]   s2_data_q;
  logic [BLOCK_BIT-1:0] s2_row_q, s2_col_q;
  logic                 s2_son_q;
  logic                 s2_sat_q;

  logic s2_can, s1_can, pipe_empty, tbl_wr, zig_acc;
  logic [5:0]         rd_adr;
  logic [TBL_BIT-1:0] rd_ent;

  logic signed [PROD_BIT-1:0] prod;
  logic signed [WIDE_BIT-1:0] scaled;
  logic                       sat_hi, sat_lo;
  logic [OUT_BIT-1:0]         res;

  assign s2_can     = !s2_vld_q || idct_veri_hazir_i;
  assign s1_can     = !s1_vld_q || s2_can;
  assign pipe_empty = !s1_vld_q && !s2_vld_q;

  assign tbl_yaz_hazir_o  = (fsm_q == BOSTA) && pipe_empty;
  assign tbl_wr           = tbl_yaz_gecerli_i && tbl_yaz_hazir_o;
  // a pending table write wins; the coefficient waits one cycle and then
  // sees the freshly written entry
  assign zig_veri_hazir_o = s1_can && !((fsm_q == BOSTA) && tbl_wr);
  assign zig_acc          = zig_veri_gecerli_i && zig_veri_hazir_o;

  assign rd_adr = {zig_veri_row_i, zig_veri_col_i};
  assign rd_ent = tbl_q[sel_fix(zig_tbl_sec_i)][rd_adr];

  always_comb begin
    prod   = PROD_BIT'(signed'(s1_coef_q)) * PROD_BIT'(signed'({1'b0, s1_ent_q}));
    scaled = WIDE_BIT'(prod) <<< FRAC_BIT;
    sat_hi = scaled > MAXV;
    sat_lo = scaled < MINV;
    if (sat_hi)      res = MAXV[OUT_BIT-1:0];
    else if (sat_lo) res = MINV[OUT_BIT-1:0];
    else             res = scaled[OUT_BIT-1:0];
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      BOSTA:   if (zig_acc) fsm_d = zig_blok_son_i ? BOSALT : BLOK;
      BLOK:    if (zig_acc && zig_blok_son_i) fsm_d = BOSALT;
      BOSALT: begin
        if (zig_acc)         fsm_d = zig_blok_son_i ? BOSALT : BLOK;
        else if (pipe_empty) fsm_d = BOSTA;
      end
      default: fsm_d = BOSTA;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    hata_d = hata_q;
    if (zig_acc) begin
      if (zig_blok_son_i) begin
        cnt_d = '0;
        if (cnt_q + 7'd1 != 7'd64) hata_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int t = 0; t < TBL_NUM; t++)
        for (int i = 0; i < 64; i++)
          tbl_q[t][i] <= (t == 0) ? TBL_BIT'(LUMA[i]) : TBL_BIT'(1);
    end else if (tbl_wr) begin
      // a zero entry would wipe the coefficient, store 1 instead
      tbl_q[sel_fix(tbl_yaz_sec_i)][tbl_yaz_adr_i] <=
        (tbl_yaz_veri_i == '0) ? TBL_BIT'(1) : tbl_yaz_veri_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fsm_q  <= BOSTA;
      cnt_q  <= '0;
      hata_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      hata_q <= hata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_vld_q  <= 1'b0;
      s1_coef_q <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      s1_son_q  <= 1'b0;
      s1_ent_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_row_q  <= '0;
      s2_col_q  <= '0;
      s2_son_q  <= 1'b0;
      s2_sat_q  <= 1'b0;
    end else begin
      if (s1_can) begin
        s1_vld_q <= zig_acc;
        if (zig_acc) begin
          s1_coef_q <= zig_veri_i;
          s1_row_q  <= zig_veri_row_i;
          s1_col_q  <= zig_veri_col_i;
          s1_son_q  <= zig_blok_son_i;
          s1_ent_q  <= rd_ent;
        end
      end
      if (s2_can) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= res;
          s2_row_q  <= s1_row_q;
          s2_col_q  <= s1_col_q;
          s2_son_q  <= s1_son_q;
          s2_sat_q  <= sat_hi || sat_lo;
        end
      end
    end
  end

  assign idct_veri_o         = s2_data_q;
  assign idct_veri_row_o     = s2_row_q;
  assign idct_veri_col_o     = s2_col_q;
  assign idct_doyma_o        = s2_sat_q;
  assign idct_veri_gecerli_o = s2_vld_q;
  assign idct_blok_son_o     = s2_son_q;
  assign blok_hata_o         = hata_q;

endmodule

// File: tb/tb_dequantizer_mt.sv
// Directed + randomized bench for dequantizer_mt with a queue-based
// reference model of the dequantization rules and block bookkeeping.
module tb_dequantizer_mt;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        tbl_yaz_gecerli_i;
  logic [1:0]  tbl_yaz_sec_i;
  logic [5:0]  tbl_yaz_adr_i;
  logic [7:0]  tbl_yaz_veri_i;
  logic        tbl_yaz_hazir_o;
  logic [11:0] zig_veri_i;
  logic [2:0]  zig_veri_row_i, zig_veri_col_i;
  logic [1:0]  zig_tbl_sec_i;
  logic        zig_veri_gecerli_i, zig_blok_son_i, zig_veri_hazir_o;
  logic [23:0] idct_veri_o;
  logic [2:0]  idct_veri_row_o, idct_veri_col_o;
  logic        idct_doyma_o, idct_veri_gecerli_o, idct_blok_son_o;
  logic        idct_veri_hazir_i;
  logic        blok_hata_o;

  dequantizer_mt dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .tbl_yaz_gecerli_i(tbl_yaz_gecerli_i), .tbl_yaz_sec_i(tbl_yaz_sec_i),
    .tbl_yaz_adr_i(tbl_yaz_adr_i), .tbl_yaz_veri_i(tbl_yaz_veri_i),
    .tbl_yaz_hazir_o(tbl_yaz_hazir_o),
    .zig_veri_i(zig_veri_i), .zig_veri_row_i(zig_veri_row_i),
    .zig_veri_col_i(zig_veri_col_i), .zig_tbl_sec_i(zig_tbl_sec_i),
    .zig_veri_gecerli_i(zig_veri_gecerli_i), .zig_blok_son_i(zig_blok_son_i),
    .zig_veri_hazir_o(zig_veri_hazir_o),
    .idct_veri_o(idct_veri_o), .idct_veri_row_o(idct_veri_row_o),
    .idct_veri_col_o(idct_veri_col_o), .idct_doyma_o(idct_doyma_o),
    .idct_veri_gecerli_o(idct_veri_gecerli_o), .idct_blok_son_o(idct_blok_son_o),
    .idct_veri_hazir_i(idct_veri_hazir_i), .blok_hata_o(blok_hata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint v;
    int     row;
    int     col;
    bit     son;
    bit     sat;
    int     acc;
  } exp_t;

  exp_t exp_q[$];
  int   m_tbl[4][64];
  bit   m_err, m_open;
  int   m_cnt;
  int   checks = 0, failures = 0, cyc_n = 0;
  bit   chk_lat, rnd_rdy, bubbles;
  bit   acc, wr_acc, obs_zig_hazir, obs_tbl_hazir;
  int   q_before, last_n;
  int   blk_coef[64];
  int   blk_sel[64];
  int   LUMA[64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99 };

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 64; i++)
        m_tbl[t][i] = (t == 0) ? LUMA[i] : 1;
    exp_q.delete();
    m_err  = 1'b0;
    m_open = 1'b0;
    m_cnt  = 0;
  endfunction

  // one clock: called at the falling edge with inputs already driven
  task automatic cyc();
    exp_t   e;
    longint p;
    if (rnd_rdy) idct_veri_hazir_i = ($urandom_range(0, 3) != 0);
    #1;
    q_before      = exp_q.size();
    obs_zig_hazir = zig_veri_hazir_o;
    obs_tbl_hazir = tbl_yaz_hazir_o;
    chk("blok_hata", blok_hata_o, m_err);
    if (idct_veri_gecerli_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", idct_veri_gecerli_o, 0);
      end else begin
        e = exp_q[0];
        chk("data", $signed(idct_veri_o), e.v);
        chk("row",  idct_veri_row_o, e.row);
        chk("col",  idct_veri_col_o, e.col);
        chk("son",  idct_blok_son_o, e.son);
        chk("doyma", idct_doyma_o, e.sat);
        if (idct_veri_hazir_i) begin
          if (chk_lat) chk("latency", cyc_n - e.acc, 2);
          void'(exp_q.pop_front());
        end
      end
    end
    acc    = zig_veri_gecerli_i && zig_veri_hazir_o;
    wr_acc = tbl_yaz_gecerli_i && tbl_yaz_hazir_o;
    if (wr_acc) begin
      chk("wr_when_busy", (q_before == 0 && !m_open), 1);
      m_tbl[tbl_yaz_sec_i][tbl_yaz_adr_i] = (tbl_yaz_veri_i == 0) ? 1 : int'(tbl_yaz_veri_i);
    end
    if (acc) begin
      p = longint'($signed(zig_veri_i)) * m_tbl[zig_tbl_sec_i][zig_veri_row_i * 8 + zig_veri_col_i] * 256;
      e.sat = 1'b1;
      if (p > 64'sd8388607)       e.v = 64'sd8388607;
      else if (p < -64'sd8388608) e.v = -64'sd8388608;
      else begin e.v = p; e.sat = 1'b0; end
      e.row = zig_veri_row_i;
      e.col = zig_veri_col_i;
      e.son = zig_blok_son_i;
      e.acc = cyc_n;
      exp_q.push_back(e);
      if (zig_blok_son_i) begin
        if (m_cnt + 1 != 64) m_err = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 128;
      end
      m_open = !zig_blok_son_i;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc_n++;
  endtask

  task automatic drive(input int coef, input int idx, input int sel, input bit son);
    zig_veri_i         = 12'(coef);
    zig_veri_row_i     = 3'(idx / 8);
    zig_veri_col_i     = 3'(idx % 8);
    zig_tbl_sec_i      = 2'(sel);
    zig_blok_son_i     = son;
    zig_veri_gecerli_i = 1'b1;
  endtask

  task automatic send(input int coef, input int idx, input int sel, input bit son);
    int n;
    n = 0;
    if (bubbles && $urandom_range(0, 3) == 0) begin
      zig_veri_gecerli_i = 1'b0;
      cyc();
    end
    drive(coef, idx, sel, son);
    do begin cyc(); n++; end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", acc, 1);
    zig_veri_gecerli_i = 1'b0;
    last_n = n;
  endtask

  task automatic send_range(input int from, input int to, input int last);
    for (int i = from; i <= to; i++) send(blk_coef[i], i, blk_sel[i], i == last);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      blk_coef[i] = int'($urandom_range(0, 4095)) - 2048;
      blk_sel[i]  = int'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    zig_veri_gecerli_i = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin cyc(); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) cyc();
  endtask

  task automatic tbl_write(input int sel, input int adr, input int val);
    tbl_yaz_sec_i     = 2'(sel);
    tbl_yaz_adr_i     = 6'(adr);
    tbl_yaz_veri_i    = 8'(val);
    tbl_yaz_gecerli_i = 1'b1;
    cyc();
    chk("tbl_wr_acc", wr_acc, 1);
    tbl_yaz_gecerli_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    rstn_i = 1'b0;
    tbl_yaz_gecerli_i = 0; tbl_yaz_sec_i = 0; tbl_yaz_adr_i = 0; tbl_yaz_veri_i = 0;
    zig_veri_i = 0; zig_veri_row_i = 0; zig_veri_col_i = 0; zig_tbl_sec_i = 0;
    zig_veri_gecerli_i = 0; zig_blok_son_i = 0; idct_veri_hazir_i = 1'b1;
    chk_lat = 0; rnd_rdy = 0; bubbles = 0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", idct_veri_gecerli_o, 0);
    chk("rst_data",  idct_veri_o, 0);
    chk("rst_rowcol", {idct_veri_row_o, idct_veri_col_o}, 0);
    chk("rst_son",   idct_blok_son_o, 0);
    chk("rst_doyma", idct_doyma_o, 0);
    chk("rst_hata",  blok_hata_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    chk("idle_tbl_hazir", tbl_yaz_hazir_o, 1);
    chk("idle_zig_hazir", zig_veri_hazir_o, 1);
    @(negedge clk_i);

    // 1: 64 x (+1) through luma table, full throughput
    chk_lat = 1;
    for (int i = 0; i < 64; i++) begin blk_coef[i] = 1; blk_sel[i] = 0; end
    send_range(0, 63, 63);
    drain();
    chk("t1_hata", blok_hata_o, 0);

    // 2: table 1 entry 0 = 200, coef -3 via table 1
    tbl_write(1, 0, 200);
    fill_rand();
    blk_coef[0] = -3; blk_sel[0] = 1;
    send_range(0, 63, 63);
    drain();

    // 3: saturation both directions, zero-write stores 1; random ready/bubbles
    chk_lat = 0; rnd_rdy = 1; bubbles = 1;
    tbl_write(2, 5, 255);
    tbl_write(2, 13, 255);
    tbl_write(3, 7, 0);
    fill_rand();
    blk_coef[5]  = 2047;  blk_sel[5]  = 2;
    blk_coef[13] = -2048; blk_sel[13] = 2;
    blk_coef[7]  = 5;     blk_sel[7]  = 3;
    send_range(0, 63, 63);
    rnd_rdy = 0; idct_veri_hazir_i = 1'b1;
    drain();

    // 4: stall from empty pipeline, then mid-stream stall
    bubbles = 0;
    fill_rand();
    idct_veri_hazir_i = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(blk_coef[k], k, blk_sel[k], 1'b0);
      cyc();
      chk("t4_hazir", obs_zig_hazir, q_before < 2);
      if (acc) k++;
    end
    chk("t4_accepts", k, 2);
    zig_veri_gecerli_i = 1'b0;
    idct_veri_hazir_i  = 1'b1;
    send_range(k, 29, 63);
    idct_veri_hazir_i = 1'b0;
    k = 30;
    for (int c = 0; c < 5; c++) begin
      drive(blk_coef[k], k, blk_sel[k], 1'b0);
      cyc();
      chk("t4_mid_hazir", obs_zig_hazir, q_before < 2);
      if (acc) k++;
    end
    zig_veri_gecerli_i = 1'b0;
    idct_veri_hazir_i  = 1'b1;
    send_range(k, 63, 63);
    drain();

    // 5: table write requested mid-block waits for drain
    fill_rand();
    send_range(0, 9, 63);
    tbl_yaz_sec_i = 2'd1; tbl_yaz_adr_i = 6'd9; tbl_yaz_veri_i = 8'd77;
    tbl_yaz_gecerli_i = 1'b1;
    send_range(10, 10, 63);
    chk("t5_blocked", obs_tbl_hazir, 0);
    send_range(11, 63, 63);
    n = 0;
    do begin cyc(); n++; end while (!wr_acc && n < 20);
    chk("t5_wr_acc", wr_acc, 1);
    chk("t5_drained", exp_q.size(), 0);
    tbl_yaz_gecerli_i = 1'b0;
    cyc();
    // write and coefficient in the same cycle: write first
    tbl_yaz_sec_i = 2'd2; tbl_yaz_adr_i = 6'd0; tbl_yaz_veri_i = 8'd33;
    tbl_yaz_gecerli_i = 1'b1;
    drive(9, 0, 2, 1'b0);
    cyc();
    chk("t5_same_zig_hazir", obs_zig_hazir, 0);
    chk("t5_same_wr", wr_acc, 1);
    chk("t5_same_acc", acc, 0);
    tbl_yaz_gecerli_i = 1'b0;
    send(9, 0, 2, 1'b0);
    chk("t5_next_cycle", last_n, 1);
    fill_rand();
    blk_sel[9] = 1;
    send_range(1, 63, 63);
    drain();

    // 6: short block sets sticky error; reset mid-block
    fill_rand();
    send_range(0, 9, 9);
    drain();
    chk("t6_hata", blok_hata_o, 1);
    rnd_rdy = 1;
    fill_rand();
    send_range(0, 63, 63);
    rnd_rdy = 0; idct_veri_hazir_i = 1'b1;
    drain();
    chk("t6_hata_sticky", blok_hata_o, 1);
    fill_rand();
    send_range(0, 2, 63);
    zig_veri_gecerli_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk("t6_rst_valid", idct_veri_gecerli_o, 0);
    chk("t6_rst_data",  idct_veri_o, 0);
    chk("t6_rst_rowcol", {idct_veri_row_o, idct_veri_col_o}, 0);
    chk("t6_rst_son",   idct_blok_son_o, 0);
    chk("t6_rst_doyma", idct_doyma_o, 0);
    chk("t6_rst_hata",  blok_hata_o, 0);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (5) cyc();
    fill_rand();
    blk_coef[0] = 7;  blk_sel[0] = 2;
    blk_coef[9] = -5; blk_sel[9] = 1;
    chk_lat = 1;
    send_range(0, 63, 63);
    drain();
    chk("t6_hata_after", blok_hata_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
